// File: rtl/pipeline_pkg.sv
// Shared RV64I pipeline definitions: opcodes, ALU operations, immediate formats
// and the ID/EX pipeline-register bundle with its bubble value.
package pipeline_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmI = 3'd0,
        ImmS = 3'd1,
        ImmB = 3'd2,
        ImmU = 3'd3,
        ImmJ = 3'd4
    } imm_fmt_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        alu_op_e         alu_op;
        logic            alu_src_imm;
        logic            alu_a_pc;
        logic            word_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            illegal;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    // alt selects SUB for funct3=000 and SRA for funct3=101.
    function automatic alu_op_e alu_from_funct3(logic [2:0] funct3, logic alt);
        case (funct3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Immediate generator: instruction plus decoded format select -> sign-extended 64-bit immediate.
module id_imm_gen
    import pipeline_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [63:0] imm_o
);

    logic [6:0] opcode;
    logic       is_shift;

    assign opcode   = instr_i[6:0];
    assign is_shift = (instr_i[13:12] == 2'b01);

    always_comb begin
        imm_o = '0;
        unique case (fmt_i)
            ImmI: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
            ImmS: imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            ImmB: imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            ImmU: imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            ImmJ: imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
        // Shift-immediates carry only the shamt; funct6/funct7 bits are not immediate.
        if (fmt_i == ImmI && is_shift) begin
            if (opcode == OPC_OP_IMM) begin
                imm_o = {58'b0, instr_i[25:20]};
            end else if (opcode == OPC_OP_IMM_32) begin
                imm_o = {59'b0, instr_i[24:20]};
            end
        end
    end

endmodule

// File: rtl/pipeline_id_stage.sv
// RV64I decode stage: decode, register read, load-use stall and the ID/EX register.
// Optional ID_WB_BYPASS_EN: same-cycle writeback-to-read bypass on the operand values.
module pipeline_id_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [63:0] pc_IF,
    input  logic [31:0] instruction_IF,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        stall,
    output logic        valid_ID,
    output logic [63:0] pc_ID,
    output logic [63:0] rs1_val_ID,
    output logic [63:0] rs2_val_ID,
    output logic [63:0] imm_ID,
    output logic [4:0]  rs1_ID,
    output logic [4:0]  rs2_ID,
    output logic [4:0]  rd_ID,
    output logic [2:0]  funct3_ID,
    output logic [3:0]  alu_op_ID,
    output logic        alu_src_imm_ID,
    output logic        alu_a_pc_ID,
    output logic        word_op_ID,
    output logic        reg_write_ID,
    output logic        mem_read_ID,
    output logic        mem_write_ID,
    output logic        mem_to_reg_ID,
    output logic        branch_ID,
    output logic        jump_ID,
    output logic        jalr_ID,
    output logic        illegal_ID
);

    idex_t       idex_d, idex_q, dec;
    imm_fmt_e    fmt;
    logic [63:0] imm;
    logic [63:0] rs1_fwd, rs2_fwd;
    logic        uses_rs1, uses_rs2, has_imm, legal;
    logic [6:0]  opcode;

    assign opcode   = instruction_IF[6:0];
    assign rs1_addr = instruction_IF[19:15];
    assign rs2_addr = instruction_IF[24:20];

    id_imm_gen u_imm_gen (
        .instr_i (instruction_IF),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

`ifdef ID_WB_BYPASS_EN
    assign rs1_fwd = (wb_en && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
    assign rs2_fwd = (wb_en && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_rd, wb_data};
    assign rs1_fwd   = rs1_data;
    assign rs2_fwd   = rs2_data;
`endif

    always_comb begin
        dec      = IDEX_BUBBLE;
        fmt      = ImmI;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        has_imm  = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OPC_LUI: begin
                fmt = ImmU; has_imm = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.alu_op = AluPassB;
            end
            OPC_AUIPC: begin
                fmt = ImmU; has_imm = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.alu_a_pc = 1'b1;
            end
            OPC_JAL: begin
                fmt = ImmJ; has_imm = 1'b1;
                dec.reg_write = 1'b1; dec.jump = 1'b1;
                dec.alu_src_imm = 1'b1; dec.alu_a_pc = 1'b1;
            end
            OPC_JALR: begin
                has_imm = 1'b1; uses_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = ImmB; has_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.branch = 1'b1; dec.alu_op = AluSub;
            end
            OPC_LOAD: begin
                has_imm = 1'b1; uses_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                fmt = ImmS; has_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                has_imm = 1'b1; uses_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
                dec.word_op = (opcode == OPC_OP_IMM_32);
                dec.alu_op = alu_from_funct3(instruction_IF[14:12],
                    (instruction_IF[14:12] == 3'b101) && instruction_IF[30]);
            end
            OPC_OP, OPC_OP_32: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.reg_write = 1'b1;
                dec.word_op = (opcode == OPC_OP_32);
                dec.alu_op = alu_from_funct3(instruction_IF[14:12], instruction_IF[30]);
            end
            OPC_MISC_MEM: ;
            default: legal = 1'b0;
        endcase

        dec.valid   = 1'b1;
        dec.pc      = pc_IF;
        dec.funct3  = instruction_IF[14:12];
        dec.imm     = has_imm ? imm : '0;
        dec.rs1     = uses_rs1 ? instruction_IF[19:15] : 5'd0;
        dec.rs2     = uses_rs2 ? instruction_IF[24:20] : 5'd0;
        dec.rs1_val = uses_rs1 ? rs1_fwd : '0;
        dec.rs2_val = uses_rs2 ? rs2_fwd : '0;
        dec.rd      = dec.reg_write ? instruction_IF[11:7] : 5'd0;

        if (!legal) begin
            dec         = IDEX_BUBBLE;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.pc      = pc_IF;
            uses_rs1    = 1'b0;
            uses_rs2    = 1'b0;
        end
        if (instruction_IF == 32'h0) begin
            dec      = IDEX_BUBBLE;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

    assign stall = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                   ((uses_rs1 && instruction_IF[19:15] == idex_q.rd) ||
                    (uses_rs2 && instruction_IF[24:20] == idex_q.rd));

    always_comb begin
        idex_d = dec;
        if (flush || stall) begin
            idex_d = IDEX_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= IDEX_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_ID       = idex_q.valid;
    assign pc_ID          = idex_q.pc;
    assign rs1_val_ID     = idex_q.rs1_val;
    assign rs2_val_ID     = idex_q.rs2_val;
    assign imm_ID         = idex_q.imm;
    assign rs1_ID         = idex_q.rs1;
    assign rs2_ID         = idex_q.rs2;
    assign rd_ID          = idex_q.rd;
    assign funct3_ID      = idex_q.funct3;
    assign alu_op_ID      = idex_q.alu_op;
    assign alu_src_imm_ID = idex_q.alu_src_imm;
    assign alu_a_pc_ID    = idex_q.alu_a_pc;
    assign word_op_ID     = idex_q.word_op;
    assign reg_write_ID   = idex_q.reg_write;
    assign mem_read_ID    = idex_q.mem_read;
    assign mem_write_ID   = idex_q.mem_write;
    assign mem_to_reg_ID  = idex_q.mem_to_reg;
    assign branch_ID      = idex_q.branch;
    assign jump_ID        = idex_q.jump;
    assign jalr_ID        = idex_q.jalr;
    assign illegal_ID     = idex_q.illegal;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Directed bench for pipeline_id_stage with hand-computed expectations.
module tb_pipeline_id_stage;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [63:0] pc_IF;
    logic [31:0] instruction_IF;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        stall, valid_ID;
    logic [63:0] pc_ID, rs1_val_ID, rs2_val_ID, imm_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic [2:0]  funct3_ID;
    logic [3:0]  alu_op_ID;
    logic        alu_src_imm_ID, alu_a_pc_ID, word_op_ID, reg_write_ID, mem_read_ID;
    logic        mem_write_ID, mem_to_reg_ID, branch_ID, jump_ID, jalr_ID, illegal_ID;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] LD_X5      = 32'h00813283;
    localparam logic [31:0] ADD_X6_X5  = 32'h00128333;
    localparam logic [31:0] LD_X0      = 32'h00813003;
    localparam logic [31:0] ADD_X6_X0  = 32'h00100333;
    localparam logic [31:0] BEQ_M4     = 32'hFE000EE3;
    localparam logic [31:0] LUI_X3     = 32'h800001B7;
    localparam logic [31:0] SRAI_63    = 32'h43F0D093;
    localparam logic [31:0] FENCE      = 32'h0FF0000F;
    localparam logic [31:0] ADDI_X7_X2 = 32'h00010393;

    always #5 clk = ~clk;

    pipeline_id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .pc_IF          (pc_IF),
        .instruction_IF (instruction_IF),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .stall          (stall),
        .valid_ID       (valid_ID),
        .pc_ID          (pc_ID),
        .rs1_val_ID     (rs1_val_ID),
        .rs2_val_ID     (rs2_val_ID),
        .imm_ID         (imm_ID),
        .rs1_ID         (rs1_ID),
        .rs2_ID         (rs2_ID),
        .rd_ID          (rd_ID),
        .funct3_ID      (funct3_ID),
        .alu_op_ID      (alu_op_ID),
        .alu_src_imm_ID (alu_src_imm_ID),
        .alu_a_pc_ID    (alu_a_pc_ID),
        .word_op_ID     (word_op_ID),
        .reg_write_ID   (reg_write_ID),
        .mem_read_ID    (mem_read_ID),
        .mem_write_ID   (mem_write_ID),
        .mem_to_reg_ID  (mem_to_reg_ID),
        .branch_ID      (branch_ID),
        .jump_ID        (jump_ID),
        .jalr_ID        (jalr_ID),
        .illegal_ID     (illegal_ID)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; pc_IF = 64'h100; instruction_IF = ADDI_X1_5;
        rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;

        step(); step();
        chk("reset_valid", valid_ID, 0);
        chk("reset_imm", imm_ID, 0);
        chk("reset_rd", rd_ID, 0);
        chk("reset_pc", pc_ID, 0);
        chk("reset_regwrite", reg_write_ID, 0);
        chk("reset_stall", stall, 0);

        reset = 1'b0;
        step();
        chk("addi_imm", imm_ID, 5);
        chk("addi_rd", rd_ID, 1);
        chk("addi_src_imm", alu_src_imm_ID, 1);
        chk("addi_regwrite", reg_write_ID, 1);
        chk("addi_pc", pc_ID, 64'h100);
        chk("addi_rs2", rs2_ID, 0);

        // Load-use: one bubble then the dependent add.
        instruction_IF = LD_X5; pc_IF = 64'h104; rs1_data = 64'h1000;
        step();
        chk("ld_memread", mem_read_ID, 1);
        chk("ld_rd", rd_ID, 5);
        chk("ld_imm", imm_ID, 8);
        instruction_IF = ADD_X6_X5; pc_IF = 64'h108; rs1_data = 64'h1111; rs2_data = 64'h2222;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_rs1_addr", rs1_addr, 5);
        step();
        chk("lu_bubble_valid", valid_ID, 0);
        chk("lu_bubble_memread", mem_read_ID, 0);
        chk("lu_stall_drop", stall, 0);
        step();
        chk("add_valid", valid_ID, 1);
        chk("add_rs1", rs1_ID, 5);
        chk("add_rs2", rs2_ID, 1);
        chk("add_rd", rd_ID, 6);
        chk("add_rs1_val", rs1_val_ID, 64'h1111);
        chk("add_alu_op", alu_op_ID, 0);

        // Loads into x0 never cause a hazard.
        instruction_IF = LD_X0;
        step();
        instruction_IF = ADD_X6_X0;
        #1;
        chk("x0_no_stall", stall, 0);

        // Flush together with stall.
        instruction_IF = LD_X5;
        step();
        instruction_IF = ADD_X6_X5; flush = 1'b1;
        #1;
        chk("flush_stall_seen", stall, 1);
        step();
        flush = 1'b0;
        chk("flush_valid", valid_ID, 0);
        chk("flush_rd", rd_ID, 0);
        chk("flush_pc", pc_ID, 0);

        instruction_IF = 32'h0;
        step();
        chk("bubble_valid", valid_ID, 0);
        chk("bubble_illegal", illegal_ID, 0);

        // Reset while a stall is pending.
        instruction_IF = LD_X5;
        step();
        instruction_IF = ADD_X6_X5;
        #1;
        chk("rst_stall_before", stall, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_stall_after", stall, 0);
        chk("rst_valid", valid_ID, 0);

        instruction_IF = BEQ_M4;
        step();
        chk("beq_imm", imm_ID, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_branch", branch_ID, 1);
        chk("beq_regwrite", reg_write_ID, 0);

        instruction_IF = LUI_X3;
        step();
        chk("lui_imm", imm_ID, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd", rd_ID, 3);
        chk("lui_alu_op", alu_op_ID, 10);
        chk("lui_rs1", rs1_ID, 0);

        instruction_IF = SRAI_63;
        step();
        chk("srai_alu_op", alu_op_ID, 7);
        chk("srai_shamt", imm_ID[5:0], 63);
        chk("srai_word", word_op_ID, 0);

        instruction_IF = 32'hFFFF_FFFF;
        step();
        chk("ill_flag", illegal_ID, 1);
        chk("ill_valid", valid_ID, 1);
        chk("ill_regwrite", reg_write_ID, 0);
        chk("ill_rd", rd_ID, 0);

        instruction_IF = 32'h0000_0004;
        step();
        chk("ill_lowbits", illegal_ID, 1);

        instruction_IF = FENCE;
        step();
        chk("fence_valid", valid_ID, 1);
        chk("fence_illegal", illegal_ID, 0);
        chk("fence_regwrite", reg_write_ID, 0);

        instruction_IF = ADDI_X7_X2; rs1_data = '0;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 64'hDEAD;
        step();
`ifdef ID_WB_BYPASS_EN
        chk("bypass_rs1", rs1_val_ID, 64'hDEAD);
`else
        chk("bypass_rs1", rs1_val_ID, 64'h0);
`endif
        wb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
